// File: rtl/reg_spec_pipe.sv
// Register-specifier decode with DEPTH-stage in-flight destination tracking, RAW stall and
// late overflow redirect. Define REG_SPEC_WB_BYPASS_EN to drop the last stage from hazard matching.
module reg_spec_pipe #(
  parameter int INSN_W     = 32,
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int OVF_STAGE  = 0,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31,
  parameter int RD_LSB     = 22,
  parameter int RS_LSB     = 17,
  parameter int RT_LSB     = 12,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [INSN_W-1:0] issue_insn,
  input  logic              wr_en,
  input  logic              rd_a_en,
  input  logic              rd_b_en,
  input  logic              setx_en,
  input  logic              jal_en,
  input  logic              rd_rs_cmp,
  input  logic              bex_en,
  input  logic              ovf,
  input  logic              flush,
  output logic [REG_W-1:0]  ctrl_a,
  output logic [REG_W-1:0]  ctrl_b,
  output logic [REG_W-1:0]  ctrl_write,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_ctrl_write,
  output logic [CNT_W-1:0]  stall_count
);

`ifdef REG_SPEC_WB_BYPASS_EN
  localparam int HZ_STAGES = DEPTH - 1;
`else
  localparam int HZ_STAGES = DEPTH;
`endif

  logic [DEPTH-1:0]            v_reg, v_next;
  logic [DEPTH-1:0][REG_W-1:0] dst_reg, dst_next;
  logic [CNT_W-1:0]            stall_count_reg, stall_count_next;
  logic [DEPTH-1:0]            match_a, match_b;
  logic                        hz_a, hz_b, issue_take;
  logic [REG_W-1:0]            status_id, link_id;
  logic                        unused_ok;

  assign status_id = REG_W'(STATUS_REG);
  assign link_id   = REG_W'(LINK_REG);

  // Only the specifier fields of the instruction word matter here.
  assign unused_ok = ^{issue_insn, ovf};

  always_comb begin
    ctrl_write = setx_en ? status_id :
                 jal_en  ? link_id   : issue_insn[RD_LSB +: REG_W];
    ctrl_b     = bex_en    ? status_id :
                 rd_rs_cmp ? issue_insn[RD_LSB +: REG_W] : issue_insn[RT_LSB +: REG_W];
    ctrl_a     = bex_en ? '0 : issue_insn[RS_LSB +: REG_W];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hz
      if (gi < HZ_STAGES) begin : g_on
        assign match_a[gi] = v_reg[gi] && (dst_reg[gi] == ctrl_a);
        assign match_b[gi] = v_reg[gi] && (dst_reg[gi] == ctrl_b);
      end else begin : g_off
        assign match_a[gi] = 1'b0;
        assign match_b[gi] = 1'b0;
      end
    end
  endgenerate

  assign hz_a       = rd_a_en && (ctrl_a != '0) && (|match_a);
  assign hz_b       = rd_b_en && (ctrl_b != '0) && (|match_b);
  assign stall      = issue_valid && (hz_a || hz_b) && !flush;
  assign issue_take = issue_valid && !stall && !flush;

  // Register 0 is never marked live, so it can never become a hazard source.
  assign v_next[0]   = issue_take && wr_en && (ctrl_write != '0);
  assign dst_next[0] = issue_take ? ctrl_write : '0;

  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      if (gi == OVF_STAGE + 1) begin : g_ovf
        // Overflow turns whatever leaves OVF_STAGE into a live status-register write.
        assign v_next[gi]   = !flush && (ovf || v_reg[gi-1]);
        assign dst_next[gi] = flush ? '0 : (ovf ? status_id : dst_reg[gi-1]);
      end else begin : g_plain
        assign v_next[gi]   = !flush && v_reg[gi-1];
        assign dst_next[gi] = flush ? '0 : dst_reg[gi-1];
      end
    end
  endgenerate

  assign stall_count_next = (stall && (stall_count_reg != '1)) ?
                            stall_count_reg + CNT_W'(1) : stall_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_reg           <= '0;
      dst_reg         <= '0;
      stall_count_reg <= '0;
    end else begin
      v_reg           <= v_next;
      dst_reg         <= dst_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign wb_valid      = v_reg[DEPTH-1];
  assign wb_ctrl_write = v_reg[DEPTH-1] ? dst_reg[DEPTH-1] : '0;
  assign stall_count   = stall_count_reg;

endmodule

// File: tb/tb_reg_spec_pipe.sv
// Directed bench for reg_spec_pipe: write-back specifiers go through a scoreboard queue,
// decode/stall/reset behaviour is checked inline.
module tb_reg_spec_pipe;
  localparam int DEPTH = 3;
`ifdef REG_SPEC_WB_BYPASS_EN
  localparam int NSTALL = DEPTH - 1;
`else
  localparam int NSTALL = DEPTH;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid, wr_en, rd_a_en, rd_b_en, setx_en, jal_en, rd_rs_cmp, bex_en, ovf, flush;
  logic [31:0] issue_insn;
  logic [4:0]  ctrl_a, ctrl_b, ctrl_write, wb_ctrl_write;
  logic        stall, wb_valid;
  logic [15:0] stall_count;

  int          checks  = 0;
  int          passed  = 0;
  int          exp_cnt = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_dst;

  always #5 clock = ~clock;

  reg_spec_pipe dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_insn(issue_insn),
    .wr_en(wr_en), .rd_a_en(rd_a_en), .rd_b_en(rd_b_en), .setx_en(setx_en), .jal_en(jal_en),
    .rd_rs_cmp(rd_rs_cmp), .bex_en(bex_en), .ovf(ovf), .flush(flush),
    .ctrl_a(ctrl_a), .ctrl_b(ctrl_b), .ctrl_write(ctrl_write), .stall(stall),
    .wb_valid(wb_valid), .wb_ctrl_write(wb_ctrl_write), .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs, input int rt);
    return (32'(rd) << 22) | (32'(rs) << 17) | (32'(rt) << 12);
  endfunction

  task automatic clr();
    issue_valid = 0; issue_insn = '0; wr_en = 0; rd_a_en = 0; rd_b_en = 0;
    setx_en = 0; jal_en = 0; rd_rs_cmp = 0; bex_en = 0; ovf = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 1) tick();
  endtask

  // Holds the current reader on the inputs through the expected stall window.
  task automatic expect_stall(input string name);
    for (int k = 0; k < NSTALL; k++) begin
      #1;
      check(name, stall, 1);
      tick();
      exp_cnt++;
    end
    #1;
    check({name, "_release"}, stall, 0);
  endtask

  // Scoreboard monitor: every live write-back must match the next queued specifier.
  always @(negedge clock) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL wb_unexpected: got wb_ctrl_write=%0d, required no write-back", wb_ctrl_write);
      end else begin
        exp_dst = exp_q.pop_front();
        $display("wb: dst=%0d expected=%0d", wb_ctrl_write, exp_dst);
        check("wb_dst", 32'(wb_ctrl_write), 32'(exp_dst));
      end
    end
  end

  initial begin
    clr();
    #1 reset = 1'b0;
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_ctrl", wb_ctrl_write, 0);
    check("rst_stall", stall, 0);
    check("rst_count", stall_count, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    tick();

    // add r3,r1,r2 reaches write-back three edges after issue
    issue_valid = 1; issue_insn = mk(3, 1, 2); wr_en = 1; rd_a_en = 1; rd_b_en = 1;
    #1;
    check("add_ctrl_write", ctrl_write, 3);
    check("add_ctrl_a", ctrl_a, 1);
    check("add_ctrl_b", ctrl_b, 2);
    check("add_no_stall", stall, 0);
    exp_q.push_back(5'd3);
    tick(); clr();
    tick(); tick();
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_ctrl", wb_ctrl_write, 3);
    tick();
    check("add_wb_gone", wb_valid, 0);

    // RAW on port A: reader of r3 right behind the writer
    issue_valid = 1; issue_insn = mk(3, 1, 2); wr_en = 1;
    exp_q.push_back(5'd3);
    tick();
    issue_insn = mk(4, 3, 0); rd_a_en = 1;
    expect_stall("raw_a_stall");
    exp_q.push_back(5'd4);
    tick(); clr();
    drain();
    check("raw_a_count", stall_count, 32'(exp_cnt));

    // jal tracks r31; bex reads only r30 so it proceeds
    issue_valid = 1; issue_insn = mk(7, 0, 0); wr_en = 1; jal_en = 1;
    #1;
    check("jal_ctrl_write", ctrl_write, 31);
    exp_q.push_back(5'd31);
    tick(); clr();
    issue_valid = 1; issue_insn = mk(0, 9, 9); bex_en = 1; rd_a_en = 1; rd_b_en = 1;
    #1;
    check("bex_ctrl_a", ctrl_a, 0);
    check("bex_ctrl_b", ctrl_b, 30);
    check("bex_no_stall", stall, 0);
    tick(); clr();
    drain();

    // sw-style compare: B reads the rd field
    issue_insn = mk(6, 1, 2); rd_rs_cmp = 1;
    #1;
    check("cmp_ctrl_b", ctrl_b, 6);
    clr();

    // setx writes r30, so a following bex stalls on port B
    issue_valid = 1; issue_insn = mk(2, 0, 0); wr_en = 1; setx_en = 1;
    #1;
    check("setx_ctrl_write", ctrl_write, 30);
    exp_q.push_back(5'd30);
    tick(); clr();
    issue_valid = 1; issue_insn = mk(0, 9, 9); bex_en = 1; rd_b_en = 1;
    expect_stall("bex_setx_stall");
    tick(); clr();
    drain();
    check("bex_count", stall_count, 32'(exp_cnt));

    // overflow redirects r5 to r30; a later reader of r5 proceeds
    issue_valid = 1; issue_insn = mk(5, 1, 2); wr_en = 1;
    exp_q.push_back(5'd30);
    tick(); clr();
    ovf = 1;
    tick(); clr();
    issue_valid = 1; issue_insn = mk(8, 5, 0); rd_a_en = 1;
    #1;
    check("ovf_reader_no_stall", stall, 0);
    tick(); clr();
    check("ovf_wb_valid", wb_valid, 1);
    check("ovf_wb_ctrl", wb_ctrl_write, 30);
    drain();

    // overflow on a bubble still produces a live status write
    ovf = 1;
    exp_q.push_back(5'd30);
    tick(); clr();
    tick();
    check("ovf_bubble_wb_ctrl", wb_ctrl_write, 30);
    tick();
    check("ovf_bubble_gone", wb_valid, 0);

    // three writers in flight, then flush with simultaneous issue and ovf
    issue_valid = 1; wr_en = 1;
    issue_insn = mk(10, 0, 0); exp_q.push_back(5'd10); tick();
    issue_insn = mk(11, 0, 0); tick();
    issue_insn = mk(12, 0, 0); tick();
    flush = 1; ovf = 1; issue_insn = mk(13, 11, 0); rd_a_en = 1;
    #1;
    check("flush_no_stall", stall, 0);
    check("flush_wb_ctrl_before", wb_ctrl_write, 10);
    tick(); clr();
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      check("flush_wb_empty", wb_valid, 0);
      tick();
    end

    // writes to r0 are not tracked
    issue_valid = 1; issue_insn = mk(0, 1, 2); wr_en = 1;
    #1;
    check("r0_ctrl_write", ctrl_write, 0);
    tick(); clr();
    tick(); tick();
    check("r0_wb_valid", wb_valid, 0);
    tick();

    // asynchronous reset in the middle of a stall with a live write-back
    issue_valid = 1; issue_insn = mk(3, 1, 2); wr_en = 1;
    tick();
    issue_insn = mk(4, 3, 0); rd_a_en = 1;
    #1;
    check("mid_stall", stall, 1);
    tick(); tick();
    check("mid_wb_live", wb_ctrl_write, 3);
    check("mid_stall_w", stall, (NSTALL == DEPTH) ? 1 : 0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_wb_ctrl", wb_ctrl_write, 0);
    check("mid_rst_count", stall_count, 0);
    clr();
    @(negedge clock) reset = 1'b1;
    tick(); tick();

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/reg_spec_pipe.md
Name: reg_spec_pipe

Overview:
- Parametrised successor of the register-specifier controller.
- Decodes read and write register specifiers for the issuing instruction.
- Tracks pending destination writes through DEPTH in-flight pipeline stages, raising a stall on RAW hazards.
- Presents the delayed write-back specifier at the end of the pipe, and applies late overflow redirection to the status register in-flight.

Parameters:
- INSN_W, 32, instruction width
- REG_W, 5, register specifier width
- DEPTH, 3, number of tracked in-flight stages (X, M, W); minimum 2
- OVF_STAGE, 0, stage index where ovf rewrites the destination (0 = stage just after issue)
- STATUS_REG, 30, overflow/setx destination
- LINK_REG, 31, jal destination
- RD_LSB, 22, rd field LSB
- RS_LSB, 17, rs field LSB
- RT_LSB, 12, rt field LSB
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- issue_valid  in  1  instruction at issue is real
- issue_insn  in  INSN_W  issuing instruction
- wr_en  in  1  issuing instruction writes a register
- rd_a_en  in  1  issuing instruction reads port A
- rd_b_en  in  1  issuing instruction reads port B
- setx_en  in  1  setx
- jal_en  in  1  jal
- rd_rs_cmp  in  1  B port reads rd (branch compare / sw)
- bex_en  in  1  bex
- ovf  in  1  overflow for instruction in stage OVF_STAGE
- flush  in  1  kill all in-flight entries
- ctrl_a  out  REG_W  read specifier A (combinational)
- ctrl_b  out  REG_W  read specifier B (combinational)
- ctrl_write  out  REG_W  decoded destination of issuing instruction
- stall  out  1  hazard; issue must hold
- wb_valid  out  1  stage DEPTH-1 holds a live write
- wb_ctrl_write  out  REG_W  write-back specifier
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode (combinational):
  - ctrl_write = setx_en ? STATUS_REG : jal_en ? LINK_REG : insn[RD_LSB+:REG_W].
  - ctrl_b = bex_en ? STATUS_REG : rd_rs_cmp ? insn[RD_LSB+:REG_W] : insn[RT_LSB+:REG_W].
  - ctrl_a = bex_en ? 0 : insn[RS_LSB+:REG_W].
- Stage entries: {v, dst}, stages 0..DEPTH-1. Reset clears all entries: v=0, dst=0, stall_count=0.
- Hazard:
  - hz_a = rd_a_en && ctrl_a!=0 && any stage i with v_i && dst_i==ctrl_a.
  - hz_b is the same for port B.
  - stall = issue_valid && (hz_a || hz_b) && !flush.
- Shift on every clock edge: stage i+1 <= stage i.
- Stage 0 load:
  - If issue_valid && !stall && !flush: stage 0 <= {wr_en && ctrl_write!=0, ctrl_write}.
  - Otherwise stage 0 <= bubble {0,0}.
- ovf: when high, the entry entering stage OVF_STAGE+1 (or wb for last) is forced to {1, STATUS_REG}, regardless of its prior v. At OVF_STAGE=0, ovf applies to the entry leaving stage 0.
- flush: all stages <= bubble on that edge; ovf ignored that cycle; issue not captured.
- Write-back: wb_valid = v of stage DEPTH-1; wb_ctrl_write = dst of stage DEPTH-1, or 0 when !wb_valid.
- stall_count: increments on each cycle with stall=1; holds at 2^CNT_W-1.
- Register 0: never tracked, never a hazard source.
- Reset mid-operation: all entries drop immediately (asynchronous); outputs reflect empty pipe with no clock edge required.

Optional Feature:
- Macro REG_SPEC_WB_BYPASS_EN.
- Defined: stage DEPTH-1 is excluded from the hazard match; the register file writes before it reads, so the W stage causes no stall.
- Undefined: all DEPTH stages participate in the hazard match.

Test Plan:
- Reset, then add r3,r1,r2 (rd=3, rs=1, rt=2) with wr_en=1 → ctrl_write=3, ctrl_a=1, ctrl_b=2. Three cycles later, wb_valid=1 and wb_ctrl_write=3.
- add r3 followed next cycle by an instruction reading rs=3 with rd_a_en=1 → stall=1 for 2 cycles. With REG_SPEC_WB_BYPASS_EN undefined, stall=1 for 3 cycles. stall_count matches.
- jal issued, then bex → jal tracks dst 31; bex gives ctrl_a=0, ctrl_b=30 with no stall. A preceding setx causes the bex to stall.
- add r5 with ovf=1 at OVF_STAGE → wb_ctrl_write=30, not 5. A reader of r5 issued after the redirect does not stall.
- Three writers in flight, then flush=1 with a simultaneous issue → all v=0. Issue is not captured; wb_valid stays 0 for DEPTH cycles.
- add r0,r1,r2 → no tracked entry, wb_valid=0. Assert reset=0 mid-stall → stall=0 and wb_valid=0 immediately.
